// File: rtl/ram_arbiter_pkg.sv
// Shared defaults and encodings for the two-port RAM arbiter.
package ram_arbiter_pkg;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 6;

    typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_LDR = 1'b1} owner_t;
endpackage

// File: rtl/ram_arbiter_pick2.sv
// arb_pick2: combinational 2-way requester pick, fixed-priority (LDR wins) or round-robin.
module arb_pick2
    import ram_arbiter_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic   cpu_req,
    input  logic   ldr_req,
    input  owner_t last_win,
    output logic   any_req,
    output owner_t pick
);
    always_comb begin
        any_req = cpu_req | ldr_req;
        pick    = OWN_LDR;
        if (cpu_req && !ldr_req) begin
            pick = OWN_CPU;
        end else if (cpu_req && ldr_req && RR_EN && (last_win == OWN_LDR)) begin
            pick = OWN_CPU;
        end
    end
endmodule

// File: rtl/ram_arbiter.sv
// Two-requester (CPU, loader) arbiter in front of a synchronous single-port RAM.
// Define RAM_ARB_RR_EN for round-robin tie-breaking; default is fixed priority (LDR wins).
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
`ifdef RAM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    state_t            state, state_nxt;
    owner_t            last_win, rd_owner, pick;
    logic              any_req, grant, gnt_we;
    logic [DATA_W-1:0] cpu_hold, ldr_hold;

    arb_pick2 #(.RR_EN(RR_EN)) u_pick (
        .cpu_req  (cpu_req),
        .ldr_req  (ldr_req),
        .last_win (last_win),
        .any_req  (any_req),
        .pick     (pick)
    );

    always_comb begin
        // reset gates the combinational grant so nothing is accepted while reset is held
        grant      = !reset && (state == IDLE) && any_req;
        cpu_gnt    = grant && (pick == OWN_CPU);
        ldr_gnt    = grant && (pick == OWN_LDR);
        gnt_we     = (pick == OWN_LDR) ? ldr_we    : cpu_we;
        ram_addr   = (pick == OWN_LDR) ? ldr_addr  : cpu_addr;
        ram_wdata  = (pick == OWN_LDR) ? ldr_wdata : cpu_wdata;
        ram_we     = grant && gnt_we;
        cpu_stall  = cpu_req && !cpu_gnt;
        cpu_rvalid = (state == RD_WAIT) && (rd_owner == OWN_CPU);
        ldr_rvalid = (state == RD_WAIT) && (rd_owner == OWN_LDR);
        cpu_rdata  = cpu_rvalid ? ram_rdata : cpu_hold;
        ldr_rdata  = ldr_rvalid ? ram_rdata : ldr_hold;
        state_nxt  = IDLE;
        if (grant && !gnt_we) begin
            state_nxt = RD_WAIT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            last_win <= OWN_LDR;
            rd_owner <= OWN_CPU;
            cpu_hold <= '0;
            ldr_hold <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                last_win <= pick;
                rd_owner <= pick;
            end
            if (cpu_rvalid) begin
                cpu_hold <= ram_rdata;
            end
            if (ldr_rvalid) begin
                ldr_hold <= ram_rdata;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: transaction-level reference model plus directed and random scenarios.
// Honours RAM_ARB_RR_EN the same way the design does.
module tb_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [5:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_gnt, cpu_rvalid, cpu_stall;
    logic [15:0] cpu_rdata;
    logic        ldr_req = 1'b0, ldr_we = 1'b0;
    logic [5:0]  ldr_addr = '0;
    logic [15:0] ldr_wdata = '0;
    logic        ldr_gnt, ldr_rvalid;
    logic [15:0] ldr_rdata;
    logic        ram_we;
    logic [5:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;

    int vectors = 0;
    int miscompares = 0;

    ram_arbiter #(.DATA_W(16), .ADDR_W(6)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM the arbiter drives
    logic [15:0] ram [64] = '{default: '0};
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    // Reference model state: expected memory, one outstanding read, last winner, held rdata
    logic [15:0] ref_mem [64] = '{default: '0};
    bit          m_busy, m_rd_owner, m_last;
    logic [15:0] m_rd_data, m_cpu_hold, m_ldr_hold;
    bit          obs_cpu_gnt, obs_ldr_gnt, obs_cpu_stall, obs_ram_we, obs_ldr_rvalid;

    task automatic model_reset();
        m_busy = 0; m_last = 1; m_cpu_hold = '0; m_ldr_hold = '0;
    endtask

    // One clock cycle: compare against the model at negedge, advance the model at posedge
    task automatic step();
        bit          e_cg, e_lg, e_crv, e_lrv, e_we, s_we;
        logic [5:0]  s_addr;
        logic [15:0] s_wdata, e_crd, e_lrd;
        @(negedge clk);
        e_cg = 0; e_lg = 0;
        if (!m_busy) begin
            if (cpu_req && ldr_req) begin
`ifdef RAM_ARB_RR_EN
                if (m_last) e_cg = 1; else e_lg = 1;
`else
                e_lg = 1;
`endif
            end else if (cpu_req) e_cg = 1;
            else if (ldr_req) e_lg = 1;
        end
        s_we    = e_lg ? ldr_we : cpu_we;
        s_addr  = e_lg ? ldr_addr : cpu_addr;
        s_wdata = e_lg ? ldr_wdata : cpu_wdata;
        e_we    = (e_cg || e_lg) && s_we;
        e_crv   = m_busy && !m_rd_owner;
        e_lrv   = m_busy && m_rd_owner;
        e_crd   = e_crv ? m_rd_data : m_cpu_hold;
        e_lrd   = e_lrv ? m_rd_data : m_ldr_hold;
        obs_cpu_gnt = cpu_gnt; obs_ldr_gnt = ldr_gnt; obs_cpu_stall = cpu_stall;
        obs_ram_we = ram_we; obs_ldr_rvalid = ldr_rvalid;

        vectors++;
        if ({cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, cpu_stall, ram_we} !==
            {e_cg, e_lg, e_crv, e_lrv, cpu_req && !e_cg, e_we}) begin
            miscompares++;
            $display("FAIL ctl t=%0t {cg,lg,crv,lrv,stall,we} got %b%b%b%b%b%b want %b%b%b%b%b%b", $time,
                     cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, cpu_stall, ram_we,
                     e_cg, e_lg, e_crv, e_lrv, cpu_req && !e_cg, e_we);
        end
        vectors++;
        if ({cpu_rdata, ldr_rdata} !== {e_crd, e_lrd}) begin
            miscompares++;
            $display("FAIL rdata t=%0t cpu/ldr got %h/%h want %h/%h", $time, cpu_rdata, ldr_rdata, e_crd, e_lrd);
        end
        if (e_cg || e_lg) begin
            vectors++;
            if ({ram_addr, (s_we ? ram_wdata : 16'h0)} !== {s_addr, (s_we ? s_wdata : 16'h0)}) begin
                miscompares++;
                $display("FAIL ram_bus t=%0t addr/wdata got %h/%h want %h/%h", $time, ram_addr, ram_wdata, s_addr, s_wdata);
            end
        end

        @(posedge clk);
        if (m_busy) begin
            if (m_rd_owner) m_ldr_hold = m_rd_data; else m_cpu_hold = m_rd_data;
            m_busy = 0;
        end
        if (e_cg || e_lg) begin
            m_last = e_lg;
            if (s_we) ref_mem[s_addr] = s_wdata;
            else begin
                m_busy = 1; m_rd_owner = e_lg; m_rd_data = ref_mem[s_addr];
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1; cpu_req = 1; ldr_req = 1; cpu_we = 0; ldr_we = 0;
        #1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, ram_we, cpu_rdata, ldr_rdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_state gnt=%b%b rv=%b%b we=%b rd=%h/%h want all 0",
                     cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, ram_we, cpu_rdata, ldr_rdata);
        end
        cpu_req = 0; ldr_req = 0; reset = 0;
    endtask

    task automatic test_cpu_write_read();
        cpu_req = 1; cpu_we = 1; cpu_addr = 6'd5; cpu_wdata = 16'hBEEF;
        step();
        vectors++;
        if (obs_cpu_gnt !== 1'b1) begin miscompares++; $display("FAIL wr_gnt got %b want 1", obs_cpu_gnt); end
        cpu_we = 0;
        step();
        vectors++;
        if (obs_cpu_gnt !== 1'b1) begin miscompares++; $display("FAIL rd_gnt got %b want 1", obs_cpu_gnt); end
        cpu_req = 0;
        #1;
        vectors++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 16'hBEEF}) begin
            miscompares++; $display("FAIL rd_beef rvalid/rdata got %b/%h want 1/beef", cpu_rvalid, cpu_rdata);
        end
        step();
    endtask

    task automatic test_tie();
        int cpu_gc = -1, ldr_gc = -1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 6'd10; cpu_wdata = 16'hA0A0;
        step(); cpu_req = 0;
        ldr_req = 1; ldr_we = 1; ldr_addr = 6'd20; ldr_wdata = 16'hB0B0;
        step(); ldr_req = 0;
        test_reset();
        cpu_req = 1; cpu_we = 0; ldr_req = 1; ldr_we = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (obs_cpu_gnt) begin cpu_gc = c; cpu_req = 0; end
            if (obs_ldr_gnt) begin ldr_gc = c; ldr_req = 0; end
        end
        vectors++;
`ifdef RAM_ARB_RR_EN
        if (cpu_gc != 0 || ldr_gc != 2) begin
            miscompares++; $display("FAIL tie_order cpu/ldr grant cycle got %0d/%0d want 0/2", cpu_gc, ldr_gc);
        end
`else
        if (ldr_gc != 0 || cpu_gc != 2) begin
            miscompares++; $display("FAIL tie_order cpu/ldr grant cycle got %0d/%0d want 2/0", cpu_gc, ldr_gc);
        end
`endif
    endtask

    task automatic test_ldr_stream();
        int idx = 0, stalls = 0, cpu_c = -1;
        test_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'd7;
        for (int c = 0; c < 20; c++) begin
            ldr_req = (idx < 8); ldr_we = 1; ldr_addr = 6'(idx); ldr_wdata = 16'h1000 + 16'(idx);
            step();
            if (obs_cpu_stall) stalls++;
            if (obs_ldr_gnt) idx++;
            if (obs_cpu_gnt) begin cpu_c = c; break; end
        end
        cpu_req = 0; ldr_req = 0;
        step(); step();
        vectors++;
`ifdef RAM_ARB_RR_EN
        if (cpu_c != 0 || stalls != 0) begin
            miscompares++; $display("FAIL stream_stall grant cycle/stalls got %0d/%0d want 0/0", cpu_c, stalls);
        end
`else
        if (cpu_c != 8 || stalls != 8) begin
            miscompares++; $display("FAIL stream_stall grant cycle/stalls got %0d/%0d want 8/8", cpu_c, stalls);
        end
`endif
    endtask

    task automatic test_reset_rd_wait();
        int rv_seen = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 6'd3; cpu_wdata = 16'h3C3C;
        step(); cpu_req = 0;
        ldr_req = 1; ldr_we = 0; ldr_addr = 6'd3;
        step(); ldr_req = 0;
        reset = 1;
        #1;
        model_reset();
        vectors++;
        if ({cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, ram_we, cpu_rdata, ldr_rdata} !== '0) begin
            miscompares++;
            $display("FAIL rdwait_reset gnt=%b%b rv=%b%b we=%b rd=%h/%h want all 0",
                     cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, ram_we, cpu_rdata, ldr_rdata);
        end
        reset = 0;
        #1;
        for (int c = 0; c < 3; c++) begin
            step();
            if (obs_ldr_rvalid) rv_seen++;
        end
        vectors++;
        if (rv_seen != 0) begin miscompares++; $display("FAIL stale_rvalid got %0d pulses want 0", rv_seen); end
        cpu_req = 1; cpu_we = 0; cpu_addr = 6'd3;
        step(); cpu_req = 0;
        #1;
        vectors++;
        if (cpu_rdata !== 16'h3C3C) begin miscompares++; $display("FAIL post_reset_read got %h want 3c3c", cpu_rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [5:0]  a [3] = '{6'd62, 6'd63, 6'd0};
        logic [15:0] d [3] = '{16'h6262, 16'h6363, 16'h0F0F};
        int wr_ok = 0;
        for (int i = 0; i < 3; i++) begin
            cpu_req = 1; cpu_we = 1; cpu_addr = a[i]; cpu_wdata = d[i];
            step();
            if (obs_cpu_gnt && obs_ram_we) wr_ok++;
        end
        vectors++;
        if (wr_ok != 3) begin miscompares++; $display("FAIL b2b_writes got %0d gnt+we cycles want 3", wr_ok); end
        for (int i = 0; i < 3; i++) begin
            cpu_req = 1; cpu_we = 0; cpu_addr = a[i];
            step(); cpu_req = 0;
            #1;
            vectors++;
            if (cpu_rdata !== d[i]) begin
                miscompares++; $display("FAIL b2b_readback addr %0d got %h want %h", a[i], cpu_rdata, d[i]);
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if (!cpu_req || obs_cpu_gnt) begin
                cpu_req = ($urandom_range(0, 3) != 0); cpu_we = $urandom_range(0, 1) == 1;
                cpu_addr = 6'($urandom_range(0, 63)); cpu_wdata = 16'($urandom);
            end else if ($urandom_range(0, 15) == 0) cpu_req = 0;
            if (!ldr_req || obs_ldr_gnt) begin
                ldr_req = ($urandom_range(0, 3) != 0); ldr_we = $urandom_range(0, 1) == 1;
                ldr_addr = 6'($urandom_range(0, 63)); ldr_wdata = 16'($urandom);
            end else if ($urandom_range(0, 15) == 0) ldr_req = 0;
            step();
        end
        cpu_req = 0; ldr_req = 0;
        step(); step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cpu_write_read();
        test_tie();
        test_ldr_stream();
        test_reset_rd_wait();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: DATA_W, default 16, word width of the RAM and both requester data ports.
REQ-002 Parameter: ADDR_W, default 6, RAM address width (64 words).
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Ports: cpu_req  input  1  CPU access request; cpu_we  input  1  write when high; cpu_addr  input  ADDR_W; cpu_wdata  input  DATA_W.
REQ-006 Ports: cpu_gnt  output  1  accept pulse; cpu_rvalid  output  1  read data valid; cpu_rdata  output  DATA_W; cpu_stall  output  1  equals cpu_req AND NOT cpu_gnt.
REQ-007 Ports: ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_rvalid, ldr_rdata: loader port, same directions, widths and meaning as the CPU port.
REQ-008 Ports: ram_we  output  1; ram_addr  output  ADDR_W; ram_wdata  output  DATA_W; ram_rdata  input  DATA_W, valid the cycle after the address (synchronous RAM).

Function
REQ-009 FSM states: IDLE, RD_WAIT; the only transition is IDLE->RD_WAIT on a granted read, and RD_WAIT always returns to IDLE after exactly one cycle.
REQ-010 In IDLE with at least one req high, exactly one requester is granted combinationally in the same cycle; its gnt is high for that one cycle only.
REQ-011 The granted requester's we/addr/wdata drive ram_we/ram_addr/ram_wdata in the grant cycle; ram_we is forced 0 in all other cycles.
REQ-012 Granted write: completes in the grant cycle, no rvalid, FSM stays IDLE; back-to-back writes are accepted every cycle.
REQ-013 Granted read: the next cycle is RD_WAIT; the owner's rvalid is high for exactly that cycle with rdata = ram_rdata.
REQ-014 In RD_WAIT, no grant is issued; pending requests wait (read throughput is one per 2 cycles).
REQ-015 Both rdata outputs hold their last returned value when rvalid is low.
REQ-016 Requesters hold req/we/addr/wdata stable until gnt; a req dropped before gnt is a withdrawn request and needs no cleanup.
REQ-017 A simultaneous request is resolved per REQ-022/023; the loser sees gnt=0 and stall=1 (CPU).
REQ-018 A 1-bit last-winner register (0=CPU, 1=LDR) updates on every grant.

Reset
REQ-019 On reset assertion, asynchronously: FSM=IDLE, all gnt/rvalid=0, ram_we=0, rdata outputs=0, last-winner=LDR.
REQ-020 Reset during RD_WAIT discards the pending read; no rvalid is issued after reset release.
REQ-021 The first cycle after reset release accepts a request normally.

Configuration
REQ-022 With RAM_ARB_RR_EN defined: round-robin; on a tie the requester that is not the last-winner is granted.
REQ-023 Without RAM_ARB_RR_EN: fixed priority, LDR always wins ties; last-winner is still kept but unused.

Structure
REQ-024 Shared package holds the DATA_W/ADDR_W defaults, the FSM state encoding (IDLE=0, RD_WAIT=1) and the owner encoding (CPU=0, LDR=1).
REQ-025 One sub-module, arb_pick2 (combinational 2-way pick from req bits, last-winner and mode), is allowed; the FSM and muxing stay in ram_arbiter.

Verification
REQ-026 CPU write addr 5 = 0xBEEF, then CPU read addr 5 -> cpu_gnt pulses in both cycles, cpu_rvalid high one cycle later with cpu_rdata=0xBEEF.
REQ-027 Both req reads in the same IDLE cycle, RR build, after reset -> CPU granted first, LDR granted 2 cycles later, each rvalid only on its own port.
REQ-028 Fixed-priority build, LDR streams writes to addrs 0..7 while CPU reqs -> cpu_stall=1 for 8 cycles, CPU granted in cycle 9.
REQ-029 Reset pulsed in the RD_WAIT cycle of an LDR read of addr 3 -> ldr_rvalid never asserts, all outputs 0, next CPU read of addr 3 returns the stored value.
REQ-030 Back-to-back CPU writes addrs 62, 63, 0 (wrap-around of the address pattern) -> three consecutive gnt cycles, ram_we high for all three, readback returns all three values.
